// File: rtl/id_exe_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: opcode fields, bubble
// encoding and the per-edge action chosen by the priority logic.
package id_exe_pipe_pkg;

    localparam int REG_ADDR_W_DEFAULT  = 4;
    localparam int REG_VALUE_W_DEFAULT = 16;

    localparam logic [15:0] NOP_OPN_DEFAULT = 16'h0800;

    // Major opcode field opn[15:11]
    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_BNEZ   = 5'b00101;
    localparam logic [4:0] OP_SHIFT  = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_SP     = 5'b01100;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_CMPI   = 5'b01110;
    localparam logic [4:0] OP_MOVE   = 5'b01111;
    localparam logic [4:0] OP_LW_SP  = 5'b10010;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW_SP  = 5'b11010;
    localparam logic [4:0] OP_SW     = 5'b11011;

    // Sub-opcode opn[10:8] within OP_SP
    localparam logic [2:0] SUB_BTEQZ = 3'b000;
    localparam logic [2:0] SUB_ADDSP = 3'b011;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_LOAD
    } pipe_act_e;

    // Flush beats stall; an invalid decode slot becomes a bubble.
    function automatic pipe_act_e next_action(input logic flush, input logic stall,
                                              input logic in_valid);
        if (flush)          return ACT_BUBBLE;
        else if (stall)     return ACT_HOLD;
        else if (!in_valid) return ACT_BUBBLE;
        else                return ACT_LOAD;
    endfunction

endpackage

// File: rtl/id_exe_pipe_operand_sel.sv
// Combinational ALU operand builder: picks register values or extended
// immediates from the instruction word.
module id_operand_sel
    import id_exe_pipe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       opn,
    input  logic [DATA_W-1:0] rv1,
    input  logic [DATA_W-1:0] rv2,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] mem_write_value
);

    logic [4:0]        major;
    logic [2:0]        sub;
    logic [DATA_W-1:0] sext8, sext5, sext4, sext11, zext8, shamt;

    assign major  = opn[15:11];
    assign sub    = opn[10:8];
    assign sext8  = {{(DATA_W-8){opn[7]}}, opn[7:0]};
    assign sext5  = {{(DATA_W-5){opn[4]}}, opn[4:0]};
    assign sext4  = {{(DATA_W-4){opn[3]}}, opn[3:0]};
    assign sext11 = {{(DATA_W-11){opn[10]}}, opn[10:0]};
    assign zext8  = {{(DATA_W-8){1'b0}}, opn[7:0]};
    // A zero shift field encodes a shift by eight.
    assign shamt  = (opn[4:2] == 3'd0) ? DATA_W'(8) : {{(DATA_W-3){1'b0}}, opn[4:2]};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        op1             = rv1;
        op2             = rv2;
        mem_write_value = '0;
        unique case (major)
            OP_ADDIU, OP_CMPI, OP_LW_SP: op2 = sext8;
            OP_SW_SP: begin
                op2             = sext8;
                mem_write_value = rv2;
            end
            OP_ADDIU3: op2 = sext4;
            OP_LW:     op2 = sext5;
            OP_SW: begin
                op2             = sext5;
                mem_write_value = rv2;
            end
            OP_LI: begin
                op1 = zext8;
                op2 = '0;
            end
            OP_SHIFT: begin
                op1 = rv2;
                op2 = shamt;
            end
            OP_MOVE: begin
                op1 = rv2;
                op2 = '0;
            end
            OP_BEQZ, OP_BNEZ: op2 = '0;
            OP_B: begin
                op1 = '0;
                op2 = sext11;
            end
            OP_SP: begin
                if (sub == SUB_ADDSP)      op2 = sext8;
                else if (sub == SUB_BTEQZ) op2 = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_exe_pipe.sv
// ID/EX pipeline register with stall, flush/bubble insertion and a
// saturating bubble counter for performance debug.
module id_exe_pipe
    import id_exe_pipe_pkg::*;
#(
    parameter int          DATA_W     = REG_VALUE_W_DEFAULT,
    parameter int          REG_ADDR_W = REG_ADDR_W_DEFAULT,
    parameter logic [15:0] NOP_OPN    = NOP_OPN_DEFAULT,
    parameter int          CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     pc,
    input  logic [15:0]           opn,
    input  logic [DATA_W-1:0]     read_value1,
    input  logic [DATA_W-1:0]     read_value2,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] reg_addr,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     pc_out,
    output logic [15:0]           opn_out,
    output logic [DATA_W-1:0]     op1,
    output logic [DATA_W-1:0]     op2,
    output logic [DATA_W-1:0]     mem_write_value,
    output logic                  mem_write_out,
    output logic                  mem_read_out,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] reg_addr_out,
    output logic [CNT_W-1:0]      bubble_count
);

    logic [DATA_W-1:0] sel_op1, sel_op2, sel_mwv;
    pipe_act_e         act;

    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic [15:0]           opn_q, opn_d;
    logic [DATA_W-1:0]     op1_q, op1_d;
    logic [DATA_W-1:0]     op2_q, op2_d;
    logic [DATA_W-1:0]     mwv_q, mwv_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;
    logic                  reg_write_q, reg_write_d;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [CNT_W-1:0]      bubble_count_q, bubble_count_d;

    id_operand_sel #(.DATA_W(DATA_W)) u_operand_sel (
        .opn             (opn),
        .rv1             (read_value1),
        .rv2             (read_value2),
        .op1             (sel_op1),
        .op2             (sel_op2),
        .mem_write_value (sel_mwv)
    );

    assign act = next_action(flush, stall, in_valid);

    always_comb begin
        valid_d        = valid_q;
        pc_d           = pc_q;
        opn_d          = opn_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        mwv_d          = mwv_q;
        mem_write_d    = mem_write_q;
        mem_read_d     = mem_read_q;
        reg_write_d    = reg_write_q;
        reg_addr_d     = reg_addr_q;
        bubble_count_d = bubble_count_q;
        unique case (act)
            ACT_BUBBLE: begin
                valid_d     = 1'b0;
                pc_d        = '0;
                opn_d       = NOP_OPN;
                op1_d       = '0;
                op2_d       = '0;
                mwv_d       = '0;
                mem_write_d = 1'b0;
                mem_read_d  = 1'b0;
                reg_write_d = 1'b0;
                reg_addr_d  = '0;
                if (!(&bubble_count_q)) bubble_count_d = bubble_count_q + CNT_W'(1);
            end
            ACT_LOAD: begin
                valid_d     = 1'b1;
                pc_d        = pc;
                opn_d       = opn;
                op1_d       = sel_op1;
                op2_d       = sel_op2;
                mwv_d       = sel_mwv;
                mem_write_d = mem_write;
                mem_read_d  = mem_read;
                reg_write_d = reg_write;
                reg_addr_d  = reg_addr;
            end
            default: ;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= 1'b0;
            pc_q           <= '0;
            opn_q          <= NOP_OPN;
            op1_q          <= '0;
            op2_q          <= '0;
            mwv_q          <= '0;
            mem_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            reg_write_q    <= 1'b0;
            reg_addr_q     <= '0;
            bubble_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            pc_q           <= pc_d;
            opn_q          <= opn_d;
            op1_q          <= op1_d;
            op2_q          <= op2_d;
            mwv_q          <= mwv_d;
            mem_write_q    <= mem_write_d;
            mem_read_q     <= mem_read_d;
            reg_write_q    <= reg_write_d;
            reg_addr_q     <= reg_addr_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign out_valid       = valid_q;
    assign pc_out          = pc_q;
    assign opn_out         = opn_q;
    assign op1             = op1_q;
    assign op2             = op2_q;
    assign mem_write_value = mwv_q;
    assign mem_write_out   = mem_write_q;
    assign mem_read_out    = mem_read_q;
    assign reg_write_out   = reg_write_q;
    assign reg_addr_out    = reg_addr_q;
    assign bubble_count    = bubble_count_q;

endmodule

// File: tb/tb_id_exe_pipe.sv
// Scoreboarded random bench for id_exe_pipe: a driver pushes model predictions,
// a monitor pops and compares after every clock edge.
module tb_id_exe_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic [15:0] pc = '0, opn = '0, rv1 = '0, rv2 = '0;
    logic        mw = 1'b0, mr = 1'b0, rw = 1'b0;
    logic [3:0]  ra = '0;

    logic        out_valid, mem_write_out, mem_read_out, reg_write_out;
    logic [15:0] pc_out, opn_out, op1, op2, mem_write_value, bubble_count;
    logic [3:0]  reg_addr_out;

    logic        c2_valid, c2_mwo, c2_mro, c2_rwo;
    logic [15:0] c2_pc, c2_opn, c2_op1, c2_op2, c2_mwv;
    logic [3:0]  c2_ra;
    logic [1:0]  c2_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_exe_pipe u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .pc(pc), .opn(opn), .read_value1(rv1), .read_value2(rv2),
        .mem_write(mw), .mem_read(mr), .reg_write(rw), .reg_addr(ra),
        .out_valid(out_valid), .pc_out(pc_out), .opn_out(opn_out), .op1(op1), .op2(op2),
        .mem_write_value(mem_write_value), .mem_write_out(mem_write_out),
        .mem_read_out(mem_read_out), .reg_write_out(reg_write_out),
        .reg_addr_out(reg_addr_out), .bubble_count(bubble_count)
    );

    id_exe_pipe #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .pc(pc), .opn(opn), .read_value1(rv1), .read_value2(rv2),
        .mem_write(mw), .mem_read(mr), .reg_write(rw), .reg_addr(ra),
        .out_valid(c2_valid), .pc_out(c2_pc), .opn_out(c2_opn), .op1(c2_op1), .op2(c2_op2),
        .mem_write_value(c2_mwv), .mem_write_out(c2_mwo),
        .mem_read_out(c2_mro), .reg_write_out(c2_rwo),
        .reg_addr_out(c2_ra), .bubble_count(c2_count)
    );

    typedef struct {
        logic        v;
        logic [15:0] pc, opn, op1, op2, mwv;
        logic        mw, mr, rw;
        logic [3:0]  ra;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t exp_cur;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic exp_t reset_state();
        exp_t e;
        e = '{v: 1'b0, pc: 16'h0, opn: 16'h0800, op1: 16'h0, op2: 16'h0, mwv: 16'h0,
              mw: 1'b0, mr: 1'b0, rw: 1'b0, ra: 4'h0, cnt: 16'h0, cnt2: 2'd0};
        return e;
    endfunction

    // Reference operand rules, expressed per instruction class with integer immediates.
    function automatic void ref_ops(input logic [15:0] o, input logic [15:0] r1, input logic [15:0] r2,
                                    output logic [15:0] a, output logic [15:0] b, output logic [15:0] m);
        logic [4:0] maj;
        logic [2:0] sub;
        int imm8, imm5, imm4, imm11, sh;
        maj   = o[15:11];
        sub   = o[10:8];
        imm8  = $signed(o[7:0]);
        imm5  = $signed(o[4:0]);
        imm4  = $signed(o[3:0]);
        imm11 = $signed(o[10:0]);
        sh    = int'(o[4:2]);
        if (sh == 0) sh = 8;
        a = r1; b = r2; m = 16'h0;
        if (maj == 5'b01001 || maj == 5'b01110 || maj == 5'b10010 ||
            (maj == 5'b01100 && sub == 3'b011))         b = imm8[15:0];
        else if (maj == 5'b11010) begin                  b = imm8[15:0]; m = r2; end
        else if (maj == 5'b01000)                        b = imm4[15:0];
        else if (maj == 5'b10011)                        b = imm5[15:0];
        else if (maj == 5'b11011) begin                  b = imm5[15:0]; m = r2; end
        else if (maj == 5'b01101) begin a = {8'h00, o[7:0]}; b = 16'h0; end
        else if (maj == 5'b00110) begin a = r2; b = sh[15:0]; end
        else if (maj == 5'b01111) begin a = r2; b = 16'h0; end
        else if (maj == 5'b00100 || maj == 5'b00101 ||
                 (maj == 5'b01100 && sub == 3'b000))     b = 16'h0;
        else if (maj == 5'b00010) begin a = 16'h0; b = imm11[15:0]; end
    endfunction

    function automatic exp_t bubble_of(input exp_t cur);
        exp_t e;
        e      = reset_state();
        e.cnt  = (cur.cnt == 16'hFFFF) ? cur.cnt : cur.cnt + 16'd1;
        e.cnt2 = (cur.cnt2 == 2'd3) ? cur.cnt2 : cur.cnt2 + 2'd1;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue the predicted result.
    task automatic step(input logic st, input logic fl, input logic iv, input logic [15:0] p,
                        input logic [15:0] o, input logic [15:0] r1, input logic [15:0] r2,
                        input logic mw_i, input logic mr_i, input logic rw_i, input logic [3:0] ra_i);
        exp_t nx;
        @(negedge clk);
        stall = st; flush = fl; in_valid = iv; pc = p; opn = o; rv1 = r1; rv2 = r2;
        mw = mw_i; mr = mr_i; rw = rw_i; ra = ra_i;
        if (fl || (!st && !iv)) nx = bubble_of(exp_cur);
        else if (st)            nx = exp_cur;
        else begin
            nx = exp_cur;
            nx.v = 1'b1; nx.pc = p; nx.opn = o; nx.mw = mw_i; nx.mr = mr_i; nx.rw = rw_i; nx.ra = ra_i;
            ref_ops(o, r1, r2, nx.op1, nx.op2, nx.mwv);
        end
        exp_cur = nx;
        sb_q.push_back(nx);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_valid", 32'(out_valid), 32'(e.v));
                check("pc_out", 32'(pc_out), 32'(e.pc));
                check("opn_out", 32'(opn_out), 32'(e.opn));
                check("op1", 32'(op1), 32'(e.op1));
                check("op2", 32'(op2), 32'(e.op2));
                check("mem_write_value", 32'(mem_write_value), 32'(e.mwv));
                check("ctrl", {29'd0, mem_write_out, mem_read_out, reg_write_out},
                      {29'd0, e.mw, e.mr, e.rw});
                check("reg_addr_out", 32'(reg_addr_out), 32'(e.ra));
                check("bubble_count", 32'(bubble_count), 32'(e.cnt));
                check("c2_bubble_count", 32'(c2_count), 32'(e.cnt2));
                check("c2_out_valid", 32'(c2_valid), 32'(e.v));
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] rand_opn();
        logic [4:0] majors [16];
        logic [15:0] o;
        majors = '{5'b00010, 5'b00100, 5'b00101, 5'b00110, 5'b01000, 5'b01001, 5'b01100, 5'b01101,
                   5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
        o = 16'($urandom);
        o[15:11] = majors[$urandom_range(0, 15)];
        if (o[15:11] == 5'b01100 && $urandom_range(0, 1) == 1)
            o[10:8] = ($urandom_range(0, 1) == 1) ? 3'b011 : 3'b000;
        return o;
    endfunction

    initial begin : driver
        exp_cur = reset_state();
        repeat (2) @(posedge clk);
        #2;
        check("rst opn_out", 32'(opn_out), 32'h0800);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst op1/op2", {op1, op2}, 32'h0);
        check("rst bubble_count", 32'(bubble_count), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h1234, 16'h49FE, 16'h1, 16'h2, 1'b1, 1'b1, 1'b1, 4'h5);
        settle();
        check("idle opn_out", 32'(opn_out), 32'h0800);
        check("idle bubble_count", 32'(bubble_count), 32'd3);
        check("idle c2 count", 32'(c2_count), 32'd3);

        repeat (2) step(1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        settle();
        check("flush bubble_count", 32'(bubble_count), 32'd5);
        check("c2 saturate", 32'(c2_count), 32'd3);

        step(1'b0, 1'b0, 1'b1, 16'h0100, 16'h49FE, 16'h0010, 16'h7777, 1'b0, 1'b0, 1'b1, 4'h1);
        settle();
        check("addiu op1", 32'(op1), 32'h0010);
        check("addiu op2", 32'(op2), 32'hFFFE);
        check("addiu valid", 32'(out_valid), 32'h1);

        step(1'b0, 1'b0, 1'b1, 16'h0101, 16'hDA61, 16'h1000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 4'h0);
        settle();
        check("sw op1", 32'(op1), 32'h1000);
        check("sw op2", 32'(op2), 32'h0001);
        check("sw mem_write_value", 32'(mem_write_value), 32'hBEEF);
        check("sw mem_write_out", 32'(mem_write_out), 32'h1);

        step(1'b0, 1'b0, 1'b1, 16'h0102, 16'h3140, 16'h5555, 16'h0003, 1'b0, 1'b0, 1'b1, 4'h1);
        settle();
        check("sll op1", 32'(op1), 32'h0003);
        check("sll op2", 32'(op2), 32'h0008);

        step(1'b0, 1'b0, 1'b1, 16'h0103, 16'h6A5A, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0, 1'b1, 4'h2);
        repeat (2) step(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h49FE, 16'h1, 16'h2, 1'b1, 1'b1, 1'b0, 4'hF);
        settle();
        check("stall li op1", 32'(op1), 32'h005A);
        check("stall li opn_out", 32'(opn_out), 32'h6A5A);
        check("stall li pc_out", 32'(pc_out), 32'h0103);
        check("stall bubble_count", 32'(bubble_count), 32'd5);

        step(1'b1, 1'b1, 1'b1, 16'h0104, 16'h49FE, 16'h1, 16'h2, 1'b1, 1'b1, 1'b1, 4'h3);
        settle();
        check("stall+flush valid", 32'(out_valid), 32'h0);
        check("stall+flush opn_out", 32'(opn_out), 32'h0800);
        check("stall+flush count", 32'(bubble_count), 32'd6);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 16'($urandom), rand_opn(), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end

        step(1'b0, 1'b0, 1'b1, 16'h0200, 16'h49FE, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b1, 4'h7);
        step(1'b1, 1'b0, 1'b1, 16'h0201, 16'h3140, 16'h0, 16'h3, 1'b0, 1'b0, 1'b0, 4'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst valid", 32'(out_valid), 32'h0);
        check("async rst opn_out", 32'(opn_out), 32'h0800);
        check("async rst data", {pc_out, op1}, 32'h0);
        check("async rst ctrl", {27'd0, mem_write_out, mem_read_out, reg_write_out, reg_addr_out == 4'h0},
              32'h1);
        check("async rst count", {bubble_count, 14'd0, c2_count}, 32'h0);
        exp_cur = reset_state();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                 16'($urandom), rand_opn(), 16'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
        end
        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
